fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response
// pairing with a PC queue, and a small instruction buffer to decode.
module fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] ALIGN = ~DATA_WIDTH'(3);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0] osd_q, osd_d;
  logic [CW-1:0] kill_q, kill_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] pcq_q [DEPTH];
  logic [PW-1:0] pwr_q, prd_q;

  logic [DATA_WIDTH-1:0] bd_q [DEPTH];
  logic [DATA_WIDTH-1:0] bp_q [DEPTH];
  logic [PW-1:0] bwr_q, brd_q;

  logic [CW:0] used;
  logic credit, req_fire, rsp_fire;
  logic drop, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign used   = {1'b0, osd_q} + {1'b0, cnt_q};
  assign credit = used < (CW+1)'(DEPTH);

  // Gated by rst so the request drops the moment reset asserts.
  assign imem_req_valid = rst & ~redirect_valid & credit;
  assign imem_req_addr  = pc_q & ALIGN;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid & (osd_q != '0);
  assign drop     = redirect_valid | (kill_q != '0);
  assign push     = rsp_fire & ~drop;

  assign instr_valid = cnt_q != '0;
  assign instr       = bd_q[brd_q];
  assign instr_pc    = bp_q[brd_q];
  assign pop         = instr_valid & instr_ready;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = redirect_pc & ALIGN;
    else if (req_fire)
      pc_d = pc_q + DATA_WIDTH'(4);

    osd_d = osd_q + CW'(req_fire) - CW'(rsp_fire);

    kill_d = kill_q;
    if (redirect_valid)
      kill_d = osd_q - CW'(rsp_fire);
    else if (rsp_fire && kill_q != '0)
      kill_d = kill_q - 1'b1;

    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (redirect_valid)
      cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      osd_q  <= '0;
      kill_q <= '0;
      cnt_q  <= '0;
      pwr_q  <= '0;
      prd_q  <= '0;
      bwr_q  <= '0;
      brd_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcq_q[i] <= '0;
        bd_q[i]  <= '0;
        bp_q[i]  <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      osd_q  <= osd_d;
      kill_q <= kill_d;
      cnt_q  <= cnt_d;
      if (req_fire) begin
        pcq_q[pwr_q] <= imem_req_addr;
        pwr_q        <= nxt(pwr_q);
      end
      if (rsp_fire)
        prd_q <= nxt(prd_q);
      if (push) begin
        bd_q[bwr_q] <= imem_rsp_data;
        bp_q[bwr_q] <= pcq_q[prd_q];
      end
      if (redirect_valid) begin
        bwr_q <= '0;
        brd_q <= '0;
      end else begin
        if (push) bwr_q <= nxt(bwr_q);
        if (pop)  brd_q <= nxt(brd_q);
      end
    end
  end

endmodule
